// File: rtl/pkt_stream_arbiter_if.sv
// rtl/pkt_stream_arbiter_if.sv - multi-port packet stream bundle shared by the sources and the arbiter
interface pkt_stream_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = 64
);
  logic [NUM_PORTS-1:0]        io_in_valid;
  logic [NUM_PORTS-1:0]        io_in_ready;
  logic [NUM_PORTS-1:0]        io_in_last;
  logic [NUM_PORTS*DATA_W-1:0] io_in_data;
  logic [NUM_PORTS*KEEP_W-1:0] io_in_keep;
  logic                        io_out_valid;
  logic                        io_out_ready;
  logic                        io_out_last;
  logic [DATA_W-1:0]           io_out_data;
  logic [KEEP_W-1:0]           io_out_keep;

  // Arbiter view: consumes the source streams, drives the merged stream.
  modport slave (
    input  io_in_valid, io_in_last, io_in_data, io_in_keep, io_out_ready,
    output io_in_ready, io_out_valid, io_out_last, io_out_data, io_out_keep
  );

  // Environment view: sources plus downstream sink.
  modport master (
    output io_in_valid, io_in_last, io_in_data, io_in_keep, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_last, io_out_data, io_out_keep
  );
endinterface

// File: rtl/pkt_stream_arbiter.sv
// rtl/pkt_stream_arbiter.sv - packet-atomic round-robin stream arbiter (optional counters: PKT_STREAM_ARBITER_STATS_EN)
module pkt_stream_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_enable,
  pkt_stream_arbiter_if.slave      io_s,
  output logic [NUM_PORTS-1:0]     io_grant,
  output logic                     io_busy
`ifdef PKT_STREAM_ARBITER_STATS_EN
  ,
  input  logic                     io_stats_clear,
  output logic [NUM_PORTS*32-1:0]  io_pkt_count
`endif
);
  localparam int PTR_W = $clog2(NUM_PORTS);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     w_rr_ptr_nxt;
  logic [NUM_PORTS-1:0] r_grant;
  logic [NUM_PORTS-1:0] w_grant_nxt;
  logic [PTR_W-1:0]     w_pick;
  logic                 w_pick_found;
  logic                 w_locked;
  logic                 w_owner_valid;
  logic                 w_xfer_last;

  // While locked, rr_ptr always holds the owner, so one search starting
  // at rr_ptr+1 serves both the idle pick and the back-to-back re-pick.

  // Round-robin search: first valid port after rr_ptr, wrapping, ending at rr_ptr itself.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] w_idx;
    w_pick       = r_rr_ptr;
    w_pick_found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      w_idx = PTR_W'(idx);
      if (!w_pick_found && io_s.io_in_valid[w_idx]) begin
        w_pick       = w_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  // Zero-latency pass-through of the owner; fields are forced to zero on bubbles.
  always_comb begin
    w_locked          = (r_state == ST_LOCKED);
    w_owner_valid     = w_locked && io_s.io_in_valid[r_rr_ptr];
    io_s.io_out_valid = w_owner_valid;
    io_s.io_out_data  = '0;
    io_s.io_out_keep  = '0;
    io_s.io_out_last  = 1'b0;
    if (w_owner_valid) begin
      io_s.io_out_data = io_s.io_in_data[int'(r_rr_ptr)*DATA_W +: DATA_W];
      io_s.io_out_keep = io_s.io_in_keep[int'(r_rr_ptr)*KEEP_W +: KEEP_W];
      io_s.io_out_last = io_s.io_in_last[r_rr_ptr];
    end
    // Ready is steered by grant alone so it never waits on the port's own valid.
    io_s.io_in_ready  = w_locked ? (NUM_PORTS'(io_s.io_out_ready) << r_rr_ptr) : '0;
    w_xfer_last       = w_owner_valid && io_s.io_out_ready && io_s.io_in_last[r_rr_ptr];
  end

  // Next-state: grant on any request when enabled; hand over only at a last-beat transfer.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (io_enable && w_pick_found) begin
          w_state_nxt  = ST_LOCKED;
          w_grant_nxt  = NUM_PORTS'(1) << w_pick;
          w_rr_ptr_nxt = w_pick;
        end
      end
      ST_LOCKED: begin
        if (w_xfer_last) begin
          if (io_enable && w_pick_found) begin
            w_grant_nxt  = NUM_PORTS'(1) << w_pick;
            w_rr_ptr_nxt = w_pick;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant and pointer registers; reset leaves port 0 as first in line.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= PTR_W'(NUM_PORTS - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign io_grant = r_grant;
  assign io_busy  = w_locked;

`ifdef PKT_STREAM_ARBITER_STATS_EN
  logic [31:0] r_pkt_count [NUM_PORTS];

  // Per-port packet counters; clear has priority over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || io_stats_clear) begin
      for (int p = 0; p < NUM_PORTS; p++) r_pkt_count[p] <= '0;
    end else if (w_xfer_last) begin
      r_pkt_count[r_rr_ptr] <= r_pkt_count[r_rr_ptr] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign io_pkt_count[g*32 +: 32] = r_pkt_count[g];
  end
`endif
endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// tb/tb_pkt_stream_arbiter.sv - directed vector bench for pkt_stream_arbiter
module tb_pkt_stream_arbiter;
  localparam int NP = 4;
  localparam int DW = 512;
  localparam int KW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_enable;
  logic [NP-1:0] io_grant;
  logic          io_busy;
`ifdef PKT_STREAM_ARBITER_STATS_EN
  logic             io_stats_clear;
  logic [NP*32-1:0] io_pkt_count;
`endif

  pkt_stream_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .KEEP_W(KW)) bus ();

  pkt_stream_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .KEEP_W(KW)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_enable      (io_enable),
    .io_s           (bus),
    .io_grant       (io_grant),
    .io_busy        (io_busy)
`ifdef PKT_STREAM_ARBITER_STATS_EN
    ,
    .io_stats_clear (io_stats_clear),
    .io_pkt_count   (io_pkt_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    logic          en;
    logic [NP-1:0] vld;
    logic [NP-1:0] lst;
    logic          ordy;
    logic [NP-1:0] eg;
    logic          eov;
    logic          eol;
    logic          ebusy;
    logic [NP-1:0] eirdy;
    int            src;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DW-1:0] pdata(input int p);
    logic [31:0] w;
    w = 32'hC0DE_0000 | (32'(p + 1) * 32'h0000_1111);
    return {16{w}};
  endfunction

  function automatic logic [KW-1:0] pkeep(input int p);
    logic [7:0] b;
    b = 8'(8'h11 * (p + 1));
    return {8{b}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [NP-1:0] vld,
                     input logic [NP-1:0] lst, input logic ordy, input logic [NP-1:0] eg,
                     input logic eov, input logic eol, input logic ebusy,
                     input logic [NP-1:0] eirdy, input int src);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.lst = lst; v.ordy = ordy;
    v.eg = eg; v.eov = eov; v.eol = eol; v.ebusy = ebusy; v.eirdy = eirdy; v.src = src;
    vecs.push_back(v);
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    logic [KW-1:0] exp_k;
    int            lat;
    reset = 1'b1;
    io_enable = 1'b0;
    bus.io_in_valid = '0;
    bus.io_in_last = '0;
    bus.io_out_ready = 1'b0;
`ifdef PKT_STREAM_ARBITER_STATS_EN
    io_stats_clear = 1'b0;
`endif
    for (int p = 0; p < NP; p++) begin
      bus.io_in_data[p*DW +: DW] = pdata(p);
      bus.io_in_keep[p*KW +: KW] = pkeep(p);
    end

    //  rst en  vld      lst      rdy  grant    ov ol bsy irdy    src
    add(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1); // reset state
    add(0, 1, 4'b0101, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1); // arbitration cycle
    add(0, 1, 4'b0101, 4'b0000, 1, 4'b0001, 1, 0, 1, 4'b0001,  0);
    add(0, 1, 4'b0101, 4'b0000, 1, 4'b0001, 1, 0, 1, 4'b0001,  0);
    add(0, 1, 4'b0101, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0); // beat 3 last
    add(0, 1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 1, 4'b0100,  2); // no bubble
    add(0, 1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 1, 4'b0100,  2);
    add(0, 0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 1, 4'b0100,  2); // beat 6 last
    add(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1); // reset restores rr_ptr
    add(0, 1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 1, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0, 1, 4'b0001,  0);
    add(0, 1, 4'b1111, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0);
    add(0, 1, 4'b1111, 4'b0000, 1, 4'b0010, 1, 0, 1, 4'b0010,  1);
    add(0, 1, 4'b1111, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010,  1);
    add(0, 1, 4'b1111, 4'b0000, 1, 4'b0100, 1, 0, 1, 4'b0100,  2);
    add(0, 1, 4'b1111, 4'b0100, 1, 4'b0100, 1, 1, 1, 4'b0100,  2);
    add(0, 1, 4'b1111, 4'b0000, 1, 4'b1000, 1, 0, 1, 4'b1000,  3);
    add(0, 1, 4'b1111, 4'b1000, 1, 4'b1000, 1, 1, 1, 4'b1000,  3);
    add(0, 1, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0, 1, 4'b0001,  0); // wraps to port 0
    add(0, 0, 4'b1111, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0);
    add(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 1, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1); // port 1 stall test
    add(0, 1, 4'b0011, 4'b0000, 1, 4'b0010, 1, 0, 1, 4'b0010,  1);
    add(0, 1, 4'b0011, 4'b0000, 0, 4'b0010, 1, 0, 1, 4'b0000,  1);
    add(0, 1, 4'b0011, 4'b0000, 1, 4'b0010, 1, 0, 1, 4'b0010,  1);
    add(0, 1, 4'b0011, 4'b0000, 0, 4'b0010, 1, 0, 1, 4'b0000,  1);
    add(0, 1, 4'b0001, 4'b0000, 1, 4'b0010, 0, 0, 1, 4'b0010, -1); // owner bubble
    add(0, 0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010,  1);
    add(0, 1, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1); // enable drop test
    add(0, 1, 4'b1001, 4'b0000, 1, 4'b1000, 1, 0, 1, 4'b1000,  3);
    add(0, 0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 0, 1, 4'b1000,  3);
    add(0, 0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 0, 1, 4'b1000,  3);
    add(0, 0, 4'b1001, 4'b1000, 1, 4'b1000, 1, 1, 1, 4'b1000,  3);
    add(0, 0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0); // single-beat packet
    add(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 1, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1); // reset mid-packet
    add(0, 1, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 1, 4'b0010,  1);
    add(1, 1, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 1, 4'b0010,  1);
    add(0, 1, 4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);
    add(0, 0, 4'b0011, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0);
    add(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1);

    repeat (2) @(posedge clock);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      reset            = vecs[k].rst;
      io_enable        = vecs[k].en;
      bus.io_in_valid  = vecs[k].vld;
      bus.io_in_last   = vecs[k].lst;
      bus.io_out_ready = vecs[k].ordy;
      #1;
      exp_d = vecs[k].eov ? pdata(vecs[k].src) : '0;
      exp_k = vecs[k].eov ? pkeep(vecs[k].src) : '0;
      chk($sformatf("row%0d_grant", k), DW'(io_grant), DW'(vecs[k].eg));
      chk($sformatf("row%0d_out_valid", k), DW'(bus.io_out_valid), DW'(vecs[k].eov));
      chk($sformatf("row%0d_out_last", k), DW'(bus.io_out_last), DW'(vecs[k].eol));
      chk($sformatf("row%0d_busy", k), DW'(io_busy), DW'(vecs[k].ebusy));
      chk($sformatf("row%0d_in_ready", k), DW'(bus.io_in_ready), DW'(vecs[k].eirdy));
      chk($sformatf("row%0d_out_data", k), bus.io_out_data, exp_d);
      chk($sformatf("row%0d_out_keep", k), DW'(bus.io_out_keep), DW'(exp_k));
    end

    // Arbitration latency from IDLE: port 2 requests, grant must appear one cycle later.
    @(negedge clock);
    io_enable = 1'b1;
    bus.io_in_valid = 4'b0100;
    bus.io_in_last = 4'b0100;
    bus.io_out_ready = 1'b1;
    #1;
    chk("lat_idle_grant", DW'(io_grant), DW'(4'b0000));
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      #1;
      if (io_grant == 4'b0100) begin
        lat = c;
        break;
      end
    end
    chk("lat_cycles", DW'(lat), DW'(1));
    io_enable = 1'b0;
    #1;
    chk("lat_single_last", DW'(bus.io_out_last), DW'(1'b1));
    @(negedge clock);
    bus.io_in_valid = '0;
    bus.io_in_last = '0;
    #1;
    chk("lat_back_idle", DW'(io_busy), DW'(1'b0));

`ifdef PKT_STREAM_ARBITER_STATS_EN
    // Only packets after the last reset count: port 0 once, port 2 once.
    chk("stats_p0_pre", DW'(io_pkt_count[0*32 +: 32]), DW'(32'd1));
    chk("stats_p2_pre", DW'(io_pkt_count[2*32 +: 32]), DW'(32'd1));
    io_stats_clear = 1'b1;
    @(negedge clock);
    io_stats_clear = 1'b0;
    #1;
    chk("stats_cleared", DW'(io_pkt_count), DW'(128'd0));
    io_enable = 1'b1;
    bus.io_in_valid = 4'b0100;
    bus.io_in_last = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 5) io_enable = 1'b0;
    end
    @(negedge clock);
    bus.io_in_valid = '0;
    bus.io_in_last = '0;
    #1;
    chk("stats_p2_five", DW'(io_pkt_count[2*32 +: 32]), DW'(32'd5));
    chk("stats_p0_zero", DW'(io_pkt_count[0*32 +: 32]), DW'(32'd0));
    io_enable = 1'b1;
    bus.io_in_valid = 4'b0100;
    bus.io_in_last = 4'b0100;
    @(negedge clock);
    io_stats_clear = 1'b1;
    io_enable = 1'b0;
    #1;
    chk("stats_sixth_xfer", DW'(bus.io_out_valid & bus.io_out_last), DW'(1'b1));
    @(negedge clock);
    io_stats_clear = 1'b0;
    bus.io_in_valid = '0;
    bus.io_in_last = '0;
    #1;
    chk("stats_clear_wins", DW'(io_pkt_count[2*32 +: 32]), DW'(32'd0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
